// File: rtl/regfile_param_if.sv
// Register-file port bundle: two read addresses, one write port, clear request and status.
// The slave modport is the register file; the master modport is whoever drives decode/writeback.
interface regfile_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] read_register1;
  logic [ADDR_W-1:0] read_register2;
  logic [ADDR_W-1:0] destination_register;
  logic              regdst;
  logic [DATA_W-1:0] regwritedata;
  logic              regwrite;
  logic              clear_start;
  logic              busy;
  logic              write_drop;
  logic [DATA_W-1:0] readdata1;
  logic [DATA_W-1:0] readdata2;
  // Current sequencer state (0 = IDLE, 1 = CLEAR), exposed for observation.
  logic [0:0]        state;

  modport slave (
    input  read_register1, read_register2, destination_register, regdst,
    input  regwritedata, regwrite, clear_start,
    output busy, write_drop, readdata1, readdata2, state
  );

  modport master (
    output read_register1, read_register2, destination_register, regdst,
    output regwritedata, regwrite, clear_start,
    input  busy, write_drop, readdata1, readdata2, state
  );
endinterface

// File: rtl/regfile_param.sv
// 2^ADDR_W x DATA_W register file: two registered read ports with write forwarding, one write
// port, and a multi-cycle clear sequencer. Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  regfile_param_if.slave rf
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  logic [0:0]        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;
  logic              drop_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] mem_q [NREGS];

  logic [ADDR_W-1:0] wa;
  logic              wr_ok;
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

  // wr_ok is a write that would land in storage; writes to the hardwired zero register never do.
  always_comb begin
    wa = rf.regdst ? rf.destination_register : rf.read_register2;
`ifdef REGFILE_ZERO_REG_EN
    wr_ok = rf.regwrite && (wa != '0);
`else
    wr_ok = rf.regwrite;
`endif
    rd1_next = (wr_ok && (wa == rf.read_register1)) ? rf.regwritedata : mem_q[rf.read_register1];
    rd2_next = (wr_ok && (wa == rf.read_register2)) ? rf.regwritedata : mem_q[rf.read_register2];
`ifdef REGFILE_ZERO_REG_EN
    if (rf.read_register1 == '0) rd1_next = '0;
    if (rf.read_register2 == '0) rd2_next = '0;
`endif
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (state_q == ST_CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wa] <= rf.regwritedata;
    end
  end

  // A write accepted on the clear_start edge is still stored; the sweep erases it afterwards.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rd1_q  <= rd1_next;
          rd2_q  <= rd2_next;
          drop_q <= 1'b0;
          if (rf.clear_start) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          rd1_q  <= '0;
          rd2_q  <= '0;
          drop_q <= wr_ok;
          if (ptr_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign rf.busy       = busy_q;
  assign rf.write_drop = drop_q;
  assign rf.readdata1  = rd1_q;
  assign rf.readdata2  = rd2_q;
  assign rf.state      = state_q;

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the team's 4x8 register file: 2^ADDR_W registers of DATA_W bits.
- Two synchronous read ports and one write port, with same-edge write-to-read forwarding.
- A multi-cycle clear sequencer wipes the file on command without a reset.
- Sits in the datapath between instruction decode and the ALU/writeback mux.

Parameters:
- DATA_W, 8: register width in bits.
- ADDR_W, 2: register address width; NREGS = 2^ADDR_W.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-low reset.
- read_register1  input  ADDR_W  read port 1 address.
- read_register2  input  ADDR_W  read port 2 address; also the write address when regdst=0.
- destination_register  input  ADDR_W  write address when regdst=1.
- regdst  input  1  write-address select.
- regwritedata  input  DATA_W  write data.
- regwrite  input  1  write enable.
- clear_start  input  1  one-cycle request to start the clear sequence.
- busy  output  1  high while the clear sequence runs.
- write_drop  output  1  one-cycle pulse when a write is rejected because busy=1.
- readdata1  output  DATA_W  registered read data, port 1.
- readdata2  output  DATA_W  registered read data, port 2.

Behaviour:
- Reset (RESET low, asynchronous, independent of CLK):
  - all registers = 0; readdata1 = readdata2 = 0.
  - busy = 0, write_drop = 0, state = IDLE, clear pointer = 0.
- Write address wa = regdst ? destination_register : read_register2.
- States: IDLE, CLEAR.
- IDLE, each rising edge:
  - If regwrite=1: registers[wa] <= regwritedata.
  - readdataN <= (regwrite && wa == read_registerN) ? regwritedata : registers[read_registerN].
  - Read latency is 1 cycle. The forwarded value is the newly written data, not the old contents.
  - If clear_start=1: next state CLEAR, pointer <= 0, busy <= 1.
  - A write in the same cycle as clear_start is still performed; the clear then erases it.
- CLEAR, each rising edge:
  - registers[pointer] <= 0; pointer <= pointer + 1.
  - When pointer == NREGS-1: that register is cleared, next state IDLE, busy <= 0, pointer <= 0.
  - busy is high for exactly NREGS cycles.
  - readdata1/readdata2 <= 0 on every CLEAR edge.
  - regwrite=1: write ignored, write_drop <= 1 for one cycle; otherwise write_drop <= 0.
  - clear_start ignored (no restart, no extension).
- write_drop is 0 on every IDLE edge.
- Pointer arithmetic is ADDR_W bits wide; it has no wrap beyond NREGS-1 because the FSM exits there.
- Reset asserted mid-CLEAR: immediate return to the full reset state; the sequence is not resumed.
- Reads of the same address on both ports are legal and return identical data.
- Edge cases:
  - read_register2 = wa with regdst=0 is the normal case: readdata2 gets the forwarded value.
  - Simultaneous regwrite and reads of other addresses return stored values.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired to zero.
  - Writes with wa=0 are discarded: no storage update, no forwarding, write_drop not asserted.
  - Reads of address 0 always return 0.
  - The CLEAR sequence still takes NREGS cycles.
- Undefined: register 0 is an ordinary storage register.

Test Plan:
- Reset value check (DATA_W=8, ADDR_W=2): assert RESET low mid-cycle -> readdata1/2 = 0x00 and busy = 0 immediately, with no clock edge.
- Write then read: write 0xA5 to r2 (regdst=1, destination_register=2); next cycle read_register1=2 -> readdata1 = 0xA5 one edge later.
- Forwarding:
  - r1 = 0x11 initially.
  - Same edge: regwrite=1, regdst=0, read_register2=1, regwritedata=0x3C -> readdata2 = 0x3C, not 0x11.
  - read_register1=1 on that edge also -> readdata1 = 0x3C.
- Clear sequence:
  - Fill r0..r3 = 0x01..0x04, then pulse clear_start -> busy high for exactly 4 cycles.
  - A regwrite 0xFF to r3 during busy -> write_drop pulses once and the write is lost.
  - After busy falls, all reads return 0x00.
- Reset mid-clear: RESET low in the 2nd CLEAR cycle -> busy = 0 immediately; after release, a write/read of 0x5A to r1 works normally.
- REGFILE_ZERO_REG_EN defined: write 0x77 to r0 -> read r0 = 0x00, write_drop = 0. Without the macro -> read r0 = 0x77.
